// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO symbol unpacker: word width, symbol widths, mode encoding.
package fifo_pkg;
  localparam int DATA_W = 8;
  localparam int SYM_W3 = 3;
  localparam int SYM_W4 = 4;

  typedef enum logic {
    MODE_SYM3 = 1'b0,
    MODE_SYM4 = 1'b1
  } mode_e;

  function automatic logic [2:0] sym_width(input mode_e m);
    return (m == MODE_SYM4) ? 3'(SYM_W4) : 3'(SYM_W3);
  endfunction
endpackage

// File: rtl/fifo_sym_unpacker_if.sv
// FIFO read port plus symbol-sink handshake bundle for fifo_sym_unpacker.
// The flush input only exists when built with UNPACK_FLUSH_EN.
interface fifo_sym_unpacker_if #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int CNT_W  = 5
);
  logic              bit4;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic [3:0]        sym;
  logic              sym_valid;
  logic              sym_ready;
  logic [CNT_W-1:0]  bits_held;
`ifdef UNPACK_FLUSH_EN
  logic              flush;

  modport slave  (input  bit4, fifo_empty, fifo_dout, sym_ready, flush,
                  output fifo_rd, sym, sym_valid, bits_held);
  modport master (output bit4, fifo_empty, fifo_dout, sym_ready, flush,
                  input  fifo_rd, sym, sym_valid, bits_held);
`else
  modport slave  (input  bit4, fifo_empty, fifo_dout, sym_ready,
                  output fifo_rd, sym, sym_valid, bits_held);
  modport master (output bit4, fifo_empty, fifo_dout, sym_ready,
                  input  fifo_rd, sym, sym_valid, bits_held);
`endif
endinterface

// File: rtl/bit_accum.sv
// LSB-first bit accumulator: consume shifts right by the symbol width, append inserts a
// word just above the surviving valid bits. Bits above cnt are always kept zero.
module bit_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_consume,
  input  logic [CNT_W-1:0]  i_shift,
  input  logic              i_append,
  input  logic [DATA_W-1:0] i_data,
  output logic [3:0]        o_low,
  output logic [CNT_W-1:0]  o_cnt
);
  localparam logic [CNT_W-1:0] L_WORD = CNT_W'(DATA_W);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_ins;
  logic [CNT_W-1:0] w_cnt_base;

  always_comb begin
    w_base     = i_consume ? (r_acc >> i_shift) : r_acc;
    w_cnt_base = i_consume ? (r_cnt - i_shift) : r_cnt;
    // Insert position is the bit count left after any same-cycle consume.
    w_ins      = i_append ? ({{(ACC_W-DATA_W){1'b0}}, i_data} << w_cnt_base) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_base | w_ins;
      r_cnt <= w_cnt_base + (i_append ? L_WORD : '0);
    end
  end

  assign o_low = r_acc[3:0];
  assign o_cnt = r_cnt;
endmodule

// File: rtl/fifo_sym_unpacker.sv
// Pops DATA_W-bit FIFO words and re-emits them LSB-first as 3- or 4-bit symbols (valid/ready).
// Build with UNPACK_FLUSH_EN to allow flushing a zero-padded partial symbol.
module fifo_sym_unpacker #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fifo_sym_unpacker_if.slave io
);
  import fifo_pkg::*;

  localparam logic [CNT_W-1:0] L_RD_LIM = CNT_W'(ACC_W - DATA_W);

  mode_e            r_mode;
  logic             r_rd_pend;
  logic [3:0]       w_low;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_w;
  logic             w_full;
  logic             w_flush;
  logic             w_vld;
  logic             w_take;
  logic             w_rd;

  assign w_w    = CNT_W'(sym_width(r_mode));
  assign w_full = (w_cnt >= w_w);

`ifdef UNPACK_FLUSH_EN
  assign w_flush = io.flush && io.fifo_empty && !r_rd_pend && (w_cnt != '0) && !w_full;
`else
  assign w_flush = 1'b0;
`endif

  assign w_vld  = w_full || w_flush;
  assign w_take = w_vld && io.sym_ready;
  // Pop only when a whole word is guaranteed to fit; reset also masks the strobe.
  assign w_rd   = i_rst_n && !io.fifo_empty && !r_rd_pend && (w_cnt <= L_RD_LIM);

  bit_accum #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_take && w_flush),
    .i_consume (w_take && !w_flush),
    .i_shift   (w_w),
    .i_append  (r_rd_pend),
    .i_data    (io.fifo_dout),
    .o_low     (w_low),
    .o_cnt     (w_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= MODE_SYM3;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd;
      // Width is frozen while a symbol is presented but not yet taken.
      if (!(w_vld && !io.sym_ready))
        r_mode <= mode_e'(io.bit4);
    end
  end

  assign io.fifo_rd   = w_rd;
  assign io.sym_valid = w_vld;
  assign io.sym       = !w_vld ? 4'd0 :
                        (r_mode == MODE_SYM4) ? w_low : {1'b0, w_low[2:0]};
  assign io.bits_held = w_cnt;
endmodule

// File: tb/tb_fifo_sym_unpacker.sv
// Bench for fifo_sym_unpacker: table vectors, then stall, mode-toggle, reset and flush sequences.
module tb_fifo_sym_unpacker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sym_unpacker_if io();
  fifo_sym_unpacker dut (.i_clk(clk), .i_rst_n(rst_n), .io(io));

  typedef struct packed {
    logic            bit4;
    logic [2:0]      nw;
    logic [3:0][7:0] w;
    logic [3:0]      ns;
    logic [7:0][3:0] s;
    logic [4:0]      held;
  } vec_t;

  localparam int NV = 5;
  vec_t tbl [NV];

  logic [7:0] fq[$];
  logic [3:0] sb[$];
  logic [7:0] dout_stash;
  logic       dout_pend;
  logic       r_ready, r_bit4, r_flush;
  int         n_vec = 0, n_miss = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: FIFO model and drives at negedge, then observe settled outputs.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    if (dout_pend) begin
      io.fifo_dout = dout_stash;
      dout_pend = 1'b0;
    end
    io.fifo_empty = (fq.size() == 0);
    io.sym_ready  = r_ready;
    io.bit4       = r_bit4;
`ifdef UNPACK_FLUSH_EN
    io.flush      = r_flush;
`endif
    #1;
    cyc++;
    if (io.fifo_rd) begin
      dout_stash = fq.pop_front();
      dout_pend  = 1'b1;
    end
    if (io.sym_valid && io.sym_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sym_extra: got %0h, required no symbol (cycle %0d)", io.sym, cyc);
      end else begin
        e = sb.pop_front();
        chk("sym", 32'(io.sym), 32'(e));
      end
    end
    if (io.bits_held > 5'd16) begin
      n_vec++;
      n_miss++;
      $display("FAIL cnt_bound: got %0d, required <= 16", io.bits_held);
    end
  endtask

  task automatic rst_apply();
    rst_n = 1'b0;
    #1;
    chk("rst_sym", 32'(io.sym), 0);
    chk("rst_vld", 32'(io.sym_valid), 0);
    chk("rst_rd", 32'(io.fifo_rd), 0);
    chk("rst_held", 32'(io.bits_held), 0);
    fq.delete();
    sb.delete();
    dout_pend = 1'b0;
    io.fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_apply();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic settle_chk(input string nm, input int held);
    repeat (3) tick();
    chk({nm, "_held"}, 32'(io.bits_held), held);
    chk({nm, "_vld"}, 32'(io.sym_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t_empty, t_first, n;
    logic       bq[$];
    logic [7:0] w;
    logic [3:0] hold_sym;

    tbl[0] = '0; tbl[0].bit4 = 0; tbl[0].nw = 2; tbl[0].w[0] = 8'hA5; tbl[0].w[1] = 8'h3C;
    tbl[0].ns = 5; tbl[0].s[0] = 4'h5; tbl[0].s[1] = 4'h4; tbl[0].s[2] = 4'h2;
    tbl[0].s[3] = 4'h6; tbl[0].s[4] = 4'h3; tbl[0].held = 1;
    tbl[1] = '0; tbl[1].bit4 = 1; tbl[1].nw = 2; tbl[1].w[0] = 8'hA5; tbl[1].w[1] = 8'h12;
    tbl[1].ns = 4; tbl[1].s[0] = 4'h5; tbl[1].s[1] = 4'hA; tbl[1].s[2] = 4'h2;
    tbl[1].s[3] = 4'h1; tbl[1].held = 0;
    tbl[2] = '0; tbl[2].bit4 = 1; tbl[2].nw = 3; tbl[2].w[0] = 8'hFF; tbl[2].w[1] = 8'h00;
    tbl[2].w[2] = 8'h3C; tbl[2].ns = 6; tbl[2].s[0] = 4'hF; tbl[2].s[1] = 4'hF;
    tbl[2].s[2] = 4'h0; tbl[2].s[3] = 4'h0; tbl[2].s[4] = 4'hC; tbl[2].s[5] = 4'h3; tbl[2].held = 0;
    tbl[3] = '0; tbl[3].bit4 = 0; tbl[3].nw = 1; tbl[3].w[0] = 8'h0F;
    tbl[3].ns = 2; tbl[3].s[0] = 4'h7; tbl[3].s[1] = 4'h1; tbl[3].held = 2;
    tbl[4] = '0; tbl[4].bit4 = 0; tbl[4].nw = 3; tbl[4].w[0] = 8'hFF; tbl[4].w[1] = 8'hFF;
    tbl[4].w[2] = 8'hFF; tbl[4].ns = 8; tbl[4].held = 0;
    for (int i = 0; i < 8; i++) tbl[4].s[i] = 4'h7;

    io.fifo_empty = 1'b1; io.fifo_dout = '0; io.sym_ready = 1'b0; io.bit4 = 1'b0;
    r_ready = 1'b0; r_bit4 = 1'b0; r_flush = 1'b0; dout_pend = 1'b0; dout_stash = '0;
`ifdef UNPACK_FLUSH_EN
    io.flush = 1'b0;
`endif

    for (int v = 0; v < NV; v++) begin
      do_reset();
      r_bit4 = tbl[v].bit4;
      r_ready = 1'b1;
      for (int i = 0; i < int'(tbl[v].nw); i++) fq.push_back(tbl[v].w[i]);
      for (int i = 0; i < int'(tbl[v].ns); i++) sb.push_back(tbl[v].s[i]);
      t_empty = -1; t_first = -1; n = 0;
      while (sb.size() > 0 && n < 60) begin
        tick();
        if (t_empty < 0 && !io.fifo_empty) t_empty = cyc;
        if (t_first < 0 && io.sym_valid) t_first = cyc;
        n++;
      end
      chk("vec_drain", sb.size(), 0);
      chk("vec_latency", t_first - t_empty, 2);
      settle_chk("vec", int'(tbl[v].held));
    end

    // Long stream with a 10-cycle stall; expected symbols from an independent bit model.
    do_reset();
    r_bit4 = 1'b0; r_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 8'($urandom_range(0, 255));
      fq.push_back(w);
      for (int b = 0; b < 8; b++) bq.push_back(w[b]);
    end
    while (bq.size() >= 3) begin
      sb.push_back({1'b0, bq[2], bq[1], bq[0]});
      repeat (3) void'(bq.pop_front());
    end
    repeat (6) tick();
    r_ready = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!io.sym_valid && n < 10);
    chk("stall_vld", 32'(io.sym_valid), 1);
    hold_sym = io.sym;
    repeat (10) begin
      tick();
      chk("stall_sym", {27'd0, io.sym_valid, io.sym}, {27'd0, 1'b1, hold_sym});
      if (io.bits_held > 5'd8) chk("stall_rd", 32'(io.fifo_rd), 0);
    end
    chk("stall_full", 32'(io.bits_held > 5'd8), 1);
    r_ready = 1'b1;
    drain(400);
    settle_chk("stream", 2);

    // Toggling the width select while a 3-bit symbol is stalled.
    do_reset();
    r_bit4 = 1'b0; r_ready = 1'b0;
    fq.push_back(8'hA5); fq.push_back(8'h3C);
    sb.push_back(4'h5); sb.push_back(4'h4); sb.push_back(4'h9); sb.push_back(4'h7);
    n = 0;
    do begin
      tick();
      n++;
    end while (!io.sym_valid && n < 10);
    r_bit4 = 1'b1;
    repeat (4) begin
      tick();
      chk("mode_hold", {27'd0, io.sym_valid, io.sym}, {27'd0, 1'b1, 4'h5});
    end
    r_ready = 1'b1;
    drain(40);
    settle_chk("mode", 1);

    // Reset with 7 bits held and a read outstanding.
    do_reset();
    r_bit4 = 1'b0; r_ready = 1'b1;
    fq.push_back(8'hA5);
    sb.push_back(4'h5); sb.push_back(4'h4);
    drain(30);
    settle_chk("pre", 2);
    r_ready = 1'b0;
    fq.push_back(8'h0F); fq.push_back(8'h33);
    sb.push_back(4'h6);
    n = 0;
    do begin
      tick();
      n++;
    end while (io.bits_held != 5'd10 && n < 10);
    chk("pre_held10", 32'(io.bits_held), 10);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    tick();
    chk("pre_held7", 32'(io.bits_held), 7);
    chk("pre_rd", 32'(io.fifo_rd), 1);
    tick();
    chk("pend_held7", 32'(io.bits_held), 7);
    chk("pend_rd", 32'(io.fifo_rd), 0);
    chk("pre_rst_sb", sb.size(), 0);
    rst_apply();
    r_ready = 1'b1;
    fq.push_back(8'h0F);
    sb.push_back(4'h7); sb.push_back(4'h1);
    drain(30);
    settle_chk("post_rst", 2);

`ifdef UNPACK_FLUSH_EN
    do_reset();
    r_bit4 = 1'b1; r_ready = 1'b1; r_flush = 1'b1;
    fq.push_back(8'hFF);
    sb.push_back(4'hF); sb.push_back(4'hF);
    drain(30);
    settle_chk("flush4", 0);
    do_reset();
    r_bit4 = 1'b0;
    fq.push_back(8'h07);
    sb.push_back(4'h7); sb.push_back(4'h0); sb.push_back(4'h0);
    drain(30);
    settle_chk("flush3", 0);
    r_flush = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
